data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of 32-bit words; power of two, 4 to 65536.
REQ-002 SHALL have parameter LATENCY, default 1, cycles from request acceptance to response; range 1 to 15.
REQ-003 SHALL use one clock and a reset that is synchronous and active-high; clock port clk, reset port rst.
REQ-004 SHALL have port clk  in  1  clock, all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous active-high reset.
REQ-006 SHALL have port DMEM_req  in  1  request valid.
REQ-007 SHALL have port DMEM_ready  out  1  controller can accept a request this cycle.
REQ-008 SHALL have port DMEM_we  in  1  1 = store, 0 = load.
REQ-009 SHALL have port DMEM_size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-010 SHALL have port DMEM_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-011 SHALL have port DMEM_address  in  32  byte address.
REQ-012 SHALL have port DMEM_data_in  in  32  store data, right-aligned.
REQ-013 SHALL have port DMEM_data_out  out  32  load result, right-aligned and extended.
REQ-014 SHALL have port DMEM_valid  out  1  one-cycle response strobe.
REQ-015 SHALL have port DMEM_error  out  1  access fault, meaningful only with DMEM_valid.

Function
REQ-016 SHALL accept a request in cycle c when DMEM_req and DMEM_ready are both 1; other input values are don't-care.
REQ-017 SHALL compute word index = DMEM_address[log2(DEPTH)+1:2]; higher address bits ignored, so addresses wrap modulo 4*DEPTH.
REQ-018 SHALL commit a store on the acceptance edge, writing only the addressed lanes: byte -> lane addr[1:0] from data_in[7:0]; half -> lanes addr[1]*2..+1 from data_in[15:0]; word -> all lanes.
REQ-019 SHALL sample load data on the acceptance edge, so a load accepted after a store's acceptance returns the stored value.
REQ-020 SHALL select loaded byte/half by the same lane rule and extend per DMEM_unsigned; word loads ignore DMEM_unsigned.
REQ-021 SHALL assert DMEM_valid for exactly one cycle, in cycle c+LATENCY; DMEM_data_out is 0 for stores and whenever DMEM_valid is 0.
REQ-022 SHALL implement FSM IDLE/BUSY: IDLE -> BUSY on acceptance when LATENCY>1; BUSY -> IDLE after LATENCY-1 cycles via a down-counter; LATENCY=1 never enters BUSY.
REQ-023 SHALL drive DMEM_ready 0 in cycles c+1..c+LATENCY-1 and 1 in cycle c+LATENCY, allowing a new acceptance in the response cycle (one access per LATENCY cycles).
REQ-024 SHALL leave memory contents unchanged in cycles with no accepted store.

Reset
REQ-025 SHALL, while rst=1 on a clock edge, force FSM to IDLE, counter to 0, and DMEM_valid, DMEM_error, DMEM_data_out, DMEM_ready to 0; DMEM_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-026 SHALL drop any pending response on reset; a store committed before reset stays committed; rst has priority over acceptance in the same cycle; memory contents are not cleared.

Configuration
REQ-027 SHALL, with macro DMEM_MISALIGN_CHECK_EN defined, fault half accesses with addr[0]=1, word accesses with addr[1:0]!=00, and size 11: no write, DMEM_error=1 and DMEM_data_out=0 in the response cycle, same latency.
REQ-028 SHALL, without DMEM_MISALIGN_CHECK_EN, tie DMEM_error to 0, ignore addr[0] for half and addr[1:0] for word, and treat size 11 as word.

Verification
REQ-029 SHALL cover: LATENCY=1, store word 0xDEADBEEF at 0x10, then load word at 0x10 -> valid in next cycle, data_out 0xDEADBEEF, ready held 1 throughout.
REQ-030 SHALL cover: store byte 0x80 at 0x13 over word 0x11223344 -> load word 0x80223344; load byte signed 0xFFFFFF80; load byte unsigned 0x00000080.
REQ-031 SHALL cover: LATENCY=3, load accepted cycle c -> ready 0 in c+1,c+2, valid and ready 1 in c+3; second request held during c+1..c+2 is accepted in c+3.
REQ-032 SHALL cover: DEPTH=256, store word 0xA5A5A5A5 at 0x400 -> load at 0x000 returns 0xA5A5A5A5 (wrap).
REQ-033 SHALL cover: with DMEM_MISALIGN_CHECK_EN, store word at 0x22 -> error=1, data_out 0, word at 0x20 unchanged; without it, same store writes word at 0x20 and error=0.
REQ-034 SHALL cover: LATENCY=4, rst asserted in c+2 after a load acceptance -> no valid pulse, ready 1 the cycle after rst deasserts, prior memory contents intact.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Word-organised data memory with byte/half/word load-store, fixed response latency.
// Optional alignment faulting is enabled by defining DMEM_MISALIGN_CHECK_EN.
module data_mem_ctrl #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DMEM_req,
  output logic        DMEM_ready,
  input  logic        DMEM_we,
  input  logic [1:0]  DMEM_size,
  input  logic        DMEM_unsigned,
  input  logic [31:0] DMEM_address,
  input  logic [31:0] DMEM_data_in,
  output logic [31:0] DMEM_data_out,
  output logic        DMEM_valid,
  output logic        DMEM_error
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic [3:0][7:0] mem [DEPTH];

  logic            accept;
  logic [AW-1:0]   idx;
  logic [1:0]      eff_size;
  logic            fault;
  logic [3:0]      be;
  logic [31:0]     wdata;
  logic [31:0]     rword;
  logic [31:0]     rshift;
  logic [15:0]     rhalf;
  logic [31:0]     resp_data;
  logic [31:0]     pend_data;
  logic            pend_err;
  logic            unused_addr;

  assign accept      = DMEM_req && DMEM_ready && !rst;
  assign idx         = DMEM_address[AW+1:2];
  assign unused_addr = ^DMEM_address[31:AW+2];

`ifdef DMEM_MISALIGN_CHECK_EN
  assign eff_size = DMEM_size;
  assign fault    = (DMEM_size == 2'b11) ||
                    (DMEM_size == 2'b01 && DMEM_address[0]) ||
                    (DMEM_size == 2'b10 && DMEM_address[1:0] != 2'b00);
`else
  assign eff_size = (DMEM_size == 2'b11) ? 2'b10 : DMEM_size;
  assign fault    = 1'b0;
`endif

  // Lane enables and lane-replicated store data
  always_comb begin
    be    = 4'b0000;
    wdata = 32'h0;
    case (eff_size)
      2'b00: begin
        be    = 4'b0001 << DMEM_address[1:0];
        wdata = {4{DMEM_data_in[7:0]}};
      end
      2'b01: begin
        be    = DMEM_address[1] ? 4'b1100 : 4'b0011;
        wdata = {2{DMEM_data_in[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = DMEM_data_in;
      end
    endcase
  end

  assign rword  = mem[idx];
  assign rshift = rword >> {DMEM_address[1:0], 3'b000};
  assign rhalf  = DMEM_address[1] ? rword[31:16] : rword[15:0];

  // Value the response will carry; stores and faults return zero
  always_comb begin
    resp_data = 32'h0;
    if (!DMEM_we && !fault) begin
      case (eff_size)
        2'b00:   resp_data = DMEM_unsigned ? {24'h0, rshift[7:0]}
                                           : {{24{rshift[7]}}, rshift[7:0]};
        2'b01:   resp_data = DMEM_unsigned ? {16'h0, rhalf}
                                           : {{16{rhalf[15]}}, rhalf};
        default: resp_data = rword;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept && DMEM_we && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][i] <= wdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      DMEM_ready    <= 1'b0;
      DMEM_valid    <= 1'b0;
      DMEM_error    <= 1'b0;
      DMEM_data_out <= 32'h0;
      pend_data     <= 32'h0;
      pend_err      <= 1'b0;
    end else begin
      DMEM_valid    <= 1'b0;
      DMEM_error    <= 1'b0;
      DMEM_data_out <= 32'h0;
      case (state)
        IDLE: begin
          DMEM_ready <= 1'b1;
          if (accept) begin
            if (LATENCY == 1) begin
              DMEM_valid    <= 1'b1;
              DMEM_error    <= fault;
              DMEM_data_out <= resp_data;
            end else begin
              state      <= BUSY;
              cnt        <= 4'(LATENCY - 1);
              DMEM_ready <= 1'b0;
              pend_data  <= resp_data;
              pend_err   <= fault;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          // Last busy cycle: respond and reopen in the same edge
          if (cnt == 4'd1) begin
            state         <= IDLE;
            DMEM_ready    <= 1'b1;
            DMEM_valid    <= 1'b1;
            DMEM_error    <= pend_err;
            DMEM_data_out <= pend_data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: three instances with LATENCY 1, 3 and 4.
module tb_data_mem_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst, req, we, uns, ready, valid, err;
  logic [2:0][1:0]  size;
  logic [2:0][31:0] addr, din, dout;

  int checks = 0;
  int failures = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_ctrl #(.DEPTH(256), .LATENCY(g == 0 ? 1 : (g == 1 ? 3 : 4))) u_dut (
      .clk(clk), .rst(rst[g]), .DMEM_req(req[g]), .DMEM_ready(ready[g]),
      .DMEM_we(we[g]), .DMEM_size(size[g]), .DMEM_unsigned(uns[g]),
      .DMEM_address(addr[g]), .DMEM_data_in(din[g]), .DMEM_data_out(dout[g]),
      .DMEM_valid(valid[g]), .DMEM_error(err[g]));
  end

  // Issue one request on instance d and wait (bounded) for its response
  task automatic do_access(input int d, input logic w, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] dd,
                           output logic [31:0] q, output logic e, output int lat);
    int guard = 0;
    while (!ready[d] && guard < 20) begin @(posedge clk); #1; guard++; end
    req[d] = 1'b1; we[d] = w; size[d] = sz; uns[d] = u; addr[d] = a; din[d] = dd;
    @(posedge clk); #1;
    req[d] = 1'b0;
    lat = 1;
    while (!valid[d] && lat < 20) begin @(posedge clk); #1; lat++; end
    q = dout[d]; e = err[d];
  endtask

  task automatic test_reset();
    rst = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++; if (ready[d] !== 1'b0) begin failures++; $display("FAIL rst_ready d=%0d got=%b exp=0", d, ready[d]); end
      checks++; if (valid[d] !== 1'b0) begin failures++; $display("FAIL rst_valid d=%0d got=%b exp=0", d, valid[d]); end
      checks++; if (err[d] !== 1'b0) begin failures++; $display("FAIL rst_err d=%0d got=%b exp=0", d, err[d]); end
      checks++; if (dout[d] !== 32'h0) begin failures++; $display("FAIL rst_dout d=%0d got=%h exp=0", d, dout[d]); end
    end
    rst = 3'b000;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      checks++; if (ready[d] !== 1'b1) begin failures++; $display("FAIL rst_release_ready d=%0d got=%b exp=1", d, ready[d]); end
    end
  endtask

  task automatic test_back_to_back();
    req[0] = 1; we[0] = 1; size[0] = 2'b10; uns[0] = 0; addr[0] = 32'h10; din[0] = 32'hDEADBEEF;
    @(posedge clk); #1;
    checks++; if (valid[0] !== 1'b1) begin failures++; $display("FAIL l1_st_valid got=%b exp=1", valid[0]); end
    checks++; if (ready[0] !== 1'b1) begin failures++; $display("FAIL l1_st_ready got=%b exp=1", ready[0]); end
    checks++; if (dout[0] !== 32'h0) begin failures++; $display("FAIL l1_st_dout got=%h exp=0", dout[0]); end
    we[0] = 0; din[0] = 32'h0;
    @(posedge clk); #1;
    req[0] = 0;
    checks++; if (valid[0] !== 1'b1) begin failures++; $display("FAIL l1_ld_valid got=%b exp=1", valid[0]); end
    checks++; if (ready[0] !== 1'b1) begin failures++; $display("FAIL l1_ld_ready got=%b exp=1", ready[0]); end
    checks++; if (dout[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL l1_ld_dout got=%h exp=deadbeef", dout[0]); end
    @(posedge clk); #1;
    checks++; if (valid[0] !== 1'b0) begin failures++; $display("FAIL l1_valid_drop got=%b exp=0", valid[0]); end
    checks++; if (dout[0] !== 32'h0) begin failures++; $display("FAIL l1_dout_idle got=%h exp=0", dout[0]); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] q; logic e; int lat;
    do_access(0, 1, 2'b10, 0, 32'h10, 32'h11223344, q, e, lat);
    do_access(0, 1, 2'b00, 0, 32'h13, 32'h12345680, q, e, lat);
    do_access(0, 0, 2'b10, 0, 32'h10, 32'h0, q, e, lat);
    checks++; if (q !== 32'h80223344) begin failures++; $display("FAIL byte_merge got=%h exp=80223344", q); end
    do_access(0, 0, 2'b00, 0, 32'h13, 32'h0, q, e, lat);
    checks++; if (q !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_signed got=%h exp=ffffff80", q); end
    do_access(0, 0, 2'b00, 1, 32'h13, 32'h0, q, e, lat);
    checks++; if (q !== 32'h00000080) begin failures++; $display("FAIL lb_unsigned got=%h exp=00000080", q); end
    do_access(0, 0, 2'b01, 0, 32'h12, 32'h0, q, e, lat);
    checks++; if (q !== 32'hFFFF8022) begin failures++; $display("FAIL lh_signed got=%h exp=ffff8022", q); end
    do_access(0, 0, 2'b01, 1, 32'h12, 32'h0, q, e, lat);
    checks++; if (q !== 32'h00008022) begin failures++; $display("FAIL lh_unsigned got=%h exp=00008022", q); end
    do_access(0, 1, 2'b01, 0, 32'h10, 32'hFFFFBEEF, q, e, lat);
    do_access(0, 0, 2'b10, 1, 32'h10, 32'h0, q, e, lat);
    checks++; if (q !== 32'h8022BEEF) begin failures++; $display("FAIL sh_merge got=%h exp=8022beef", q); end
    do_access(0, 0, 2'b00, 1, 32'h11, 32'h0, q, e, lat);
    checks++; if (q !== 32'h000000BE) begin failures++; $display("FAIL lbu_lane1 got=%h exp=000000be", q); end
  endtask

  task automatic test_latency3();
    logic [31:0] q; logic e; int lat;
    do_access(1, 1, 2'b10, 0, 32'h10, 32'hCAFEF00D, q, e, lat);
    checks++; if (lat !== 3) begin failures++; $display("FAIL l3_store_lat got=%0d exp=3", lat); end
    req[1] = 1; we[1] = 0; size[1] = 2'b10; uns[1] = 0; addr[1] = 32'h10;
    @(posedge clk); #1;
    size[1] = 2'b00; uns[1] = 1;
    for (int k = 1; k <= 2; k++) begin
      checks++; if (ready[1] !== 1'b0) begin failures++; $display("FAIL l3_busy_ready c+%0d got=%b exp=0", k, ready[1]); end
      checks++; if (valid[1] !== 1'b0) begin failures++; $display("FAIL l3_busy_valid c+%0d got=%b exp=0", k, valid[1]); end
      @(posedge clk); #1;
    end
    checks++; if (valid[1] !== 1'b1) begin failures++; $display("FAIL l3_resp_valid got=%b exp=1", valid[1]); end
    checks++; if (ready[1] !== 1'b1) begin failures++; $display("FAIL l3_resp_ready got=%b exp=1", ready[1]); end
    checks++; if (dout[1] !== 32'hCAFEF00D) begin failures++; $display("FAIL l3_resp_dout got=%h exp=cafef00d", dout[1]); end
    @(posedge clk); #1;
    req[1] = 0;
    checks++; if (ready[1] !== 1'b0) begin failures++; $display("FAIL l3_second_accept got=%b exp=0", ready[1]); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (valid[1] !== 1'b1) begin failures++; $display("FAIL l3_second_valid got=%b exp=1", valid[1]); end
    checks++; if (dout[1] !== 32'h0000000D) begin failures++; $display("FAIL l3_second_dout got=%h exp=0000000d", dout[1]); end
  endtask

  task automatic test_wrap();
    logic [31:0] q; logic e; int lat;
    do_access(0, 1, 2'b10, 0, 32'h400, 32'hA5A5A5A5, q, e, lat);
    do_access(0, 0, 2'b10, 0, 32'h000, 32'h0, q, e, lat);
    checks++; if (q !== 32'hA5A5A5A5) begin failures++; $display("FAIL wrap got=%h exp=a5a5a5a5", q); end
  endtask

  task automatic test_misalign();
    logic [31:0] q; logic e; int lat;
    do_access(0, 1, 2'b10, 0, 32'h20, 32'h11111111, q, e, lat);
    do_access(0, 1, 2'b10, 0, 32'h22, 32'h99999999, q, e, lat);
`ifdef DMEM_MISALIGN_CHECK_EN
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL mis_store_err got=%b exp=1", e); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL mis_store_lat got=%0d exp=1", lat); end
    do_access(0, 0, 2'b10, 0, 32'h20, 32'h0, q, e, lat);
    checks++; if (q !== 32'h11111111) begin failures++; $display("FAIL mis_unchanged got=%h exp=11111111", q); end
    do_access(0, 0, 2'b11, 0, 32'h20, 32'h0, q, e, lat);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL mis_size3_err got=%b exp=1", e); end
    checks++; if (q !== 32'h0) begin failures++; $display("FAIL mis_size3_dout got=%h exp=0", q); end
`else
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL mis_store_err got=%b exp=0", e); end
    do_access(0, 0, 2'b10, 0, 32'h20, 32'h0, q, e, lat);
    checks++; if (q !== 32'h99999999) begin failures++; $display("FAIL mis_written got=%h exp=99999999", q); end
    do_access(0, 0, 2'b11, 0, 32'h20, 32'h0, q, e, lat);
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL mis_size3_err got=%b exp=0", e); end
    checks++; if (q !== 32'h99999999) begin failures++; $display("FAIL mis_size3_dout got=%h exp=99999999", q); end
`endif
  endtask

  task automatic test_reset_pending();
    logic [31:0] q; logic e; int lat; int pulses = 0;
    do_access(2, 1, 2'b10, 0, 32'h30, 32'h5A5A1234, q, e, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL l4_store_lat got=%0d exp=4", lat); end
    req[2] = 1; we[2] = 0; size[2] = 2'b10; addr[2] = 32'h30;
    @(posedge clk); #1;
    req[2] = 0;
    @(posedge clk); #1;
    rst[2] = 1;
    @(posedge clk); #1;
    rst[2] = 0;
    checks++; if (ready[2] !== 1'b0) begin failures++; $display("FAIL l4_rst_ready got=%b exp=0", ready[2]); end
    if (valid[2]) pulses++;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (valid[2]) pulses++;
      if (k == 0) begin
        checks++; if (ready[2] !== 1'b1) begin failures++; $display("FAIL l4_release_ready got=%b exp=1", ready[2]); end
      end
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL l4_dropped_resp got=%0d exp=0", pulses); end
    do_access(2, 0, 2'b10, 0, 32'h30, 32'h0, q, e, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL l4_load_lat got=%0d exp=4", lat); end
    checks++; if (q !== 32'h5A5A1234) begin failures++; $display("FAIL l4_mem_intact got=%h exp=5a5a1234", q); end
  endtask

  initial begin
    req = '0; we = '0; uns = '0; size = '0; addr = '0; din = '0; rst = 3'b111;
    test_reset();
    test_back_to_back();
    test_byte_lanes();
    test_latency3();
    test_wrap();
    test_misalign();
    test_reset_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
